// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: opcode constants, canonical NOP and the
// instruction-fetch sequencer state type.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_STORE  = 7'd35;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EXEC,
        ERR
    } fetch_state_t;

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC selection for the fetch unit: jalr > jump > taken
// branch > sequential, plus the instruction-address-misaligned flag.
module next_pc_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    input  logic            i_branch,
    input  logic            i_jump,
    input  logic            i_jalr,
    input  logic            i_br_cond,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_jalr_tgt;

    assign w_pc_imm   = i_pc + i_imm;
    assign w_jalr_tgt = (i_rs1 + i_imm) & {{(XLEN-1){1'b1}}, 1'b0};

    always_comb begin
        o_next_pc = i_pc + XLEN'(4);
        if (i_jump && i_jalr) begin
            o_next_pc = w_jalr_tgt;
        end else if (i_jump) begin
            o_next_pc = w_pc_imm;
        end else if (i_branch && i_br_cond) begin
            o_next_pc = w_pc_imm;
        end
    end

    // Bit 0 is either cleared (JALR) or never set by a legal immediate; only bit 1 can misalign.
    assign o_misaligned = o_next_pc[1];

endmodule

// File: rtl/fetch_unit.sv
// PC register and instruction-fetch sequencer: drives the instruction-memory
// handshake, holds the fetched word and advances the PC when it retires.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int unsigned     IMEM_TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_branch,
    input  logic            i_jump,
    input  logic            i_jalr,
    input  logic            i_br_cond,
    input  logic [XLEN-1:0] i_imm_ext,
    input  logic [XLEN-1:0] i_rs1,
    input  logic            i_retire,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic [31:0]     o_instr,
    output logic [6:0]      o_op,
    output logic            o_instr_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_fetch_err
);

    localparam int unsigned CW = $clog2(IMEM_TIMEOUT + 1);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] w_next_pc;
    logic            w_misaligned;

    next_pc_gen #(
        .XLEN(XLEN)
    ) u_next_pc_gen (
        .i_pc        (r_pc),
        .i_imm       (i_imm_ext),
        .i_rs1       (i_rs1),
        .i_branch    (i_branch),
        .i_jump      (i_jump),
        .i_jalr      (i_jalr),
        .i_br_cond   (i_br_cond),
        .o_next_pc   (w_next_pc),
        .o_misaligned(w_misaligned)
    );

    // Decoder inputs only reach state through the EXEC/retire branch below.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_instr <= RV_NOP;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: begin
                    r_cnt <= '0;
                    if (i_imem_rvalid) begin
                        r_instr <= i_imem_rdata;
                        r_state <= EXEC;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_imem_rvalid) begin
                        r_instr <= i_imem_rdata;
                        r_cnt   <= '0;
                        r_state <= EXEC;
                    end else if (r_cnt == CW'(IMEM_TIMEOUT - 1)) begin
                        r_state <= ERR;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                EXEC: begin
                    if (i_retire) begin
                        if (w_misaligned) begin
                            r_state <= ERR;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= REQ;
                        end
                    end
                end
                ERR:     r_state <= ERR;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_imem_req    = (r_state == REQ) || (r_state == WAIT);
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_op          = r_instr[6:0];
    assign o_instr_valid = (r_state == EXEC);
    assign o_pc          = r_pc;
    assign o_pc_plus4    = r_pc + XLEN'(4);
    assign o_fetch_err   = (r_state == ERR);

endmodule
